rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader -- writes a downloaded, concatenated ROM image into five 2764
// (8 KiB) images: 1F, 1H, 1K, 1L, 1N, in that address order.
//
// Parameters
//   WRITE_CYCLES  clk cycles each rom_we pulse is held (1..15)
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   dl_active         download session in progress (session opens on rise)
//   dl_wr             single-cycle byte strobe
//   dl_addr, dl_data  byte offset in the concatenated image, byte value
//   dl_wait           loader is mid-write and drops any strobe
//   rom_we            one-hot write enable (bit0 1F .. bit4 1N)
//   rom_addr,rom_data address within the selected image, byte to write
//   busy              session open
//   done, error       last session completed / had a fault
//   checksum          mod-65536 sum of accepted bytes
// Configuration
//   ROM_LOADER_CHECKSUM_EN  defined: checksum accumulates; undefined: tied 0
module rom_loader #(
  parameter int WRITE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic [4:0]  rom_we,
  output logic [12:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;

  localparam logic [16:0] IMAGE_BYTES = 17'd40960;
  localparam logic [15:0] IMAGE_END   = 16'hA000;
  localparam logic [3:0]  WC_LAST     = 4'(WRITE_CYCLES - 1);

  state_t      state;
  logic        act_q;
  logic [16:0] byte_cnt;
  logic [3:0]  wcnt;

  logic rise, sess_start, accept;

  assign rise       = dl_active & ~act_q;
  assign sess_start = ((state == IDLE) || (state == DONE)) && rise;
  // A falling dl_active in ARMED wins over a same-cycle strobe.
  assign accept     = (state == ARMED) && dl_active && dl_wr && (dl_addr < IMAGE_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      // Pretend dl_active was already high so a level held across reset
      // does not look like a fresh rising edge.
      act_q    <= 1'b1;
      byte_cnt <= '0;
      wcnt     <= '0;
      dl_wait  <= 1'b0;
      rom_we   <= '0;
      rom_addr <= '0;
      rom_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      act_q <= dl_active;
      case (state)
        IDLE, DONE: begin
          if (sess_start) begin
            state    <= ARMED;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            byte_cnt <= '0;
          end
        end
        ARMED: begin
          if (!dl_active) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (byte_cnt != IMAGE_BYTES) error <= 1'b1;
          end else if (dl_wr) begin
            if (accept) begin
              state    <= WRITE;
              rom_we   <= 5'b00001 << dl_addr[15:13];
              rom_addr <= dl_addr[12:0];
              rom_data <= dl_data;
              dl_wait  <= 1'b1;
              wcnt     <= WC_LAST;
              byte_cnt <= byte_cnt + 17'd1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (dl_wr) error <= 1'b1;
          if (wcnt == 4'd0) begin
            rom_we  <= '0;
            dl_wait <= 1'b0;
            // A session that ended mid-write closes once the pulse is out.
            if (!dl_active) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (byte_cnt != IMAGE_BYTES) error <= 1'b1;
            end else begin
              state <= ARMED;
            end
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           sum_q <= '0;
    else if (sess_start) sum_q <= '0;
    else if (accept)     sum_q <= sum_q + {8'd0, dl_data};
  end
  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
